// File: rtl/pulse_generator_bank_if.sv
// Control/status bundle for pulse_generator_bank.
// master drives en/oneshot/sync/div_*; slave returns pulse/armed.
interface pulse_generator_bank_if #(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 28
);
  localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0] en;
  logic [NUM_CH-1:0] oneshot;
  logic [NUM_CH-1:0] sync;
  logic              div_we;
  logic [SEL_W-1:0]  div_sel;
  logic [WIDTH-1:0]  div_data;
  logic [NUM_CH-1:0] pulse;
  logic [NUM_CH-1:0] armed;

  modport master (
    output en, oneshot, sync,
    output div_we, div_sel, div_data,
    input  pulse, armed
  );

  modport slave (
    input  en, oneshot, sync,
    input  div_we, div_sel, div_data,
    output pulse, armed
  );
endinterface

// File: rtl/pulse_generator_bank.sv
// Bank of NUM_CH programmable periodic / one-shot tick generators.
// Ports: clk, rst (async high), bus (slave: en/oneshot/sync/div_* in, pulse/armed out).
module pulse_generator_bank #(
  parameter int               NUM_CH      = 4,
  parameter int               WIDTH       = 28,
  parameter logic [WIDTH-1:0] DEFAULT_DIV = 28'd6250000
) (
  input  logic                   clk,
  input  logic                   rst,
  pulse_generator_bank_if.slave  bus
);
  localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [WIDTH-1:0]  r_count   [NUM_CH];
  logic [WIDTH-1:0]  r_div_act [NUM_CH];
  logic [WIDTH-1:0]  r_div_shd [NUM_CH];
  logic [NUM_CH-1:0] r_pulse;
  logic [NUM_CH-1:0] r_armed;

  logic [WIDTH-1:0]  w_next_shd [NUM_CH];
  logic [NUM_CH-1:0] w_last;

  // A write landing on a wrap/sync edge goes straight through to div_act.
  // Divisor 0 behaves as 1, so the terminal count is 0 in both cases.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (bus.div_we && (bus.div_sel == SEL_W'(i)))
        w_next_shd[i] = bus.div_data;
      else
        w_next_shd[i] = r_div_shd[i];
      if (r_div_act[i] == '0)
        w_last[i] = (r_count[i] == '0);
      else
        w_last[i] = (r_count[i] == r_div_act[i] - WIDTH'(1));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_count[i]   <= '0;
        r_div_act[i] <= DEFAULT_DIV;
        r_div_shd[i] <= DEFAULT_DIV;
      end
      r_pulse <= '0;
      r_armed <= '1;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_div_shd[i] <= w_next_shd[i];
        if (bus.sync[i]) begin
          r_count[i]   <= '0;
          r_pulse[i]   <= 1'b0;
          r_armed[i]   <= 1'b1;
          r_div_act[i] <= w_next_shd[i];
        end else if (!bus.en[i] || !r_armed[i]) begin
          r_pulse[i] <= 1'b0;
        end else if (w_last[i]) begin
          r_count[i]   <= '0;
          r_pulse[i]   <= 1'b1;
          r_div_act[i] <= w_next_shd[i];
          if (bus.oneshot[i])
            r_armed[i] <= 1'b0;
        end else begin
          r_count[i] <= r_count[i] + WIDTH'(1);
          r_pulse[i] <= 1'b0;
        end
      end
    end
  end

  assign bus.pulse = r_pulse;
  assign bus.armed = r_armed;
endmodule

// File: tb/tb_pulse_generator_bank.sv
// Directed bench for pulse_generator_bank (NUM_CH=4, WIDTH=8, DEFAULT_DIV=5).
// Inputs change 1 ns after posedge; outputs sampled there too.
module tb_pulse_generator_bank;
  logic clk;
  logic rst;
  int   n_total;
  int   n_bad;
  int   n;
  int   cnt;

  pulse_generator_bank_if #(.NUM_CH(4), .WIDTH(8)) bus ();

  pulse_generator_bank #(
    .NUM_CH(4),
    .WIDTH(8),
    .DEFAULT_DIV(8'd5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int k);
    for (int i = 0; i < k; i++) tick();
  endtask

  // Edges until pulse[ch] is seen high; -1 if it never shows.
  task automatic wait_pulse(input int ch, input int lim, output int nn);
    nn = 0;
    do begin
      tick();
      nn++;
    end while (!bus.pulse[ch] && nn < lim);
    if (!bus.pulse[ch]) nn = -1;
  endtask

  task automatic wr_div(input logic [1:0] sel, input logic [7:0] d);
    bus.div_we   = 1'b1;
    bus.div_sel  = sel;
    bus.div_data = d;
    tick();
    bus.div_we   = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=0 exp=1");
    $fatal(1);
  end

  initial begin
    n_total      = 0;
    n_bad        = 0;
    rst          = 1'b1;
    bus.en       = '0;
    bus.oneshot  = '0;
    bus.sync     = '0;
    bus.div_we   = 1'b0;
    bus.div_sel  = '0;
    bus.div_data = '0;
    ticks(3);
    chk("rst_pulse", 32'(bus.pulse), 0);
    chk("rst_armed", 32'(bus.armed), 4'hF);

    // T1: default divisor 5
    rst    = 1'b0;
    bus.en = 4'b0001;
    wait_pulse(0, 20, n);
    chk("t1_first", n, 5);
    chk("t1_only0", 32'(bus.pulse), 4'b0001);
    tick();
    chk("t1_width", 32'(bus.pulse[0]), 0);
    ticks(3);
    wait_pulse(0, 20, n);
    chk("t1_period", n, 1);

    // T2: mid-period rewrite keeps current period
    ticks(2);
    wr_div(2'd0, 8'd3);
    wait_pulse(0, 20, n);
    chk("t2_old", n, 2);
    wait_pulse(0, 20, n);
    chk("t2_new_a", n, 3);
    wait_pulse(0, 20, n);
    chk("t2_new_b", n, 3);

    // T3: write-through on wrap, div 0 / 1 / 255
    bus.en = 4'b0011;
    ticks(4);
    chk("t3_pre", 32'(bus.pulse[1]), 0);
    wr_div(2'd1, 8'd0);
    chk("t3_wrap", 32'(bus.pulse[1]), 1);
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      cnt += int'(bus.pulse[1]);
    end
    chk("t3_div0", cnt, 3);
    wr_div(2'd1, 8'd1);
    cnt = int'(bus.pulse[1]);
    ticks(2);
    cnt += int'(bus.pulse[1]);
    chk("t3_div1", cnt, 2);
    wr_div(2'd1, 8'd255);
    chk("t3_wr255", 32'(bus.pulse[1]), 1);
    wait_pulse(1, 300, n);
    chk("t3_p255", n, 255);
    bus.en[1] = 1'b0;

    // T4: one-shot
    bus.oneshot[2] = 1'b1;
    bus.en[2]      = 1'b1;
    wait_pulse(2, 20, n);
    chk("t4_first", n, 5);
    chk("t4_disarm", 32'(bus.armed[2]), 0);
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      cnt += int'(bus.pulse[2]);
    end
    chk("t4_quiet", cnt, 0);
    bus.sync[2] = 1'b1;
    tick();
    bus.sync[2] = 1'b0;
    chk("t4_rearm", 32'(bus.armed[2]), 1);
    wait_pulse(2, 20, n);
    chk("t4_again", n, 5);
    chk("t4_disarm2", 32'(bus.armed[2]), 0);

    // T5: pause stretches period; sync beats en
    bus.en[3] = 1'b1;
    ticks(2);
    bus.en[3] = 1'b0;
    ticks(7);
    chk("t5_paused", 32'(bus.pulse[3]), 0);
    bus.en[3] = 1'b1;
    wait_pulse(3, 20, n);
    chk("t5_rest", n, 3);
    ticks(2);
    bus.sync[3] = 1'b1;
    tick();
    bus.sync[3] = 1'b0;
    chk("t5_sync_lo", 32'(bus.pulse[3]), 0);
    wait_pulse(3, 20, n);
    chk("t5_after", n, 5);

    // T6: async reset between edges, then per-channel write
    wait_pulse(0, 20, n);
    chk("t6_live", 32'(bus.pulse[0]), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_pulse", 32'(bus.pulse), 0);
    chk("t6_armed", 32'(bus.armed), 4'hF);
    bus.en      = '0;
    bus.oneshot = '0;
    tick();
    rst = 1'b0;
    tick();
    wr_div(2'd3, 8'd2);
    bus.en = 4'b1001;
    ticks(4);
    chk("t6_pre", 32'(bus.pulse), 0);
    tick();
    chk("t6_both", 32'(bus.pulse), 4'b1001);
    ticks(2);
    chk("t6_ch3", 32'(bus.pulse), 4'b1000);
    ticks(3);
    chk("t6_ch0", 32'(bus.pulse), 4'b0001);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
